mc_fsm_controller: RTL and testbench

//  Multi-cycle ARM control unit: sequences the shared ALU/memory datapath through fetch, decode, execute and

---
 rtl/arm_mc_pkg.sv | 63 ++++++
 rtl/cond_check.sv | 38 +++
 rtl/mc_fsm_controller.sv | 177 +++++++++++++++++
 tb/tb_mc_fsm_controller.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multi-cycle ARM control unit: FSM states,
// datapath mux selects, ALU control codes and data-processing commands.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_RDATA     = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Decoded view of a data-processing cmd field.
  typedef struct packed {
    logic [2:0] alu_ctl;
    logic       no_write;  // result is discarded (CMP, unsupported cmds)
    logic       logic_op;  // flag update only touches N and Z
  } dp_dec_t;

  function automatic dp_dec_t dp_decode(input logic [3:0] cmd);
    dp_dec_t d;
    case (cmd)
      CMD_ADD: d = '{alu_ctl: ALU_ADD, no_write: 1'b0, logic_op: 1'b0};
      CMD_SUB: d = '{alu_ctl: ALU_SUB, no_write: 1'b0, logic_op: 1'b0};
      CMD_CMP: d = '{alu_ctl: ALU_SUB, no_write: 1'b1, logic_op: 1'b0};
      CMD_AND: d = '{alu_ctl: ALU_AND, no_write: 1'b0, logic_op: 1'b1};
      CMD_ORR: d = '{alu_ctl: ALU_ORR, no_write: 1'b0, logic_op: 1'b1};
      default: d = '{alu_ctl: ALU_ADD, no_write: 1'b1, logic_op: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cond_check.sv
// Evaluates an ARM condition field against the NZCV flag register.
module cond_check
  import arm_mc_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       cond_ex
);

  logic n_s, z_s, c_s, v_s, ge_s;

  assign {n_s, z_s, c_s, v_s} = Flags;
  assign ge_s = (n_s == v_s);

  // Condition-code truth table; 1111 is treated as never-execute.
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = z_s;
      4'b0001: cond_ex = ~z_s;
      4'b0010: cond_ex = c_s;
      4'b0011: cond_ex = ~c_s;
      4'b0100: cond_ex = n_s;
      4'b0101: cond_ex = ~n_s;
      4'b0110: cond_ex = v_s;
      4'b0111: cond_ex = ~v_s;
      4'b1000: cond_ex = c_s & ~z_s;
      4'b1001: cond_ex = ~c_s | z_s;
      4'b1010: cond_ex = ge_s;
      4'b1011: cond_ex = ~ge_s;
      4'b1100: cond_ex = ~z_s & ge_s;
      4'b1101: cond_ex = z_s | ~ge_s;
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_fsm_controller.sv
// Multi-cycle ARM control unit: sequences fetch/decode/execute/writeback
// over a shared datapath, holds NZCV and gates side effects on the condition.
module mc_fsm_controller
  import arm_mc_pkg::*;
#(
  parameter logic [3:0] FLAG_RESET = 4'b0000,
  parameter bit         UNDEF_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       RegWrite,
  output logic [3:0] Flags,
  output logic [3:0] state,
  output logic       illegal
);

  state_t     state_r, state_next_s;
  logic [3:0] flags_r;
  logic       cond_ex_s, cond_ex_r;
  logic       flag_load_s, rd_pc_s;
  dp_dec_t    dp_dec_s;

  logic       pc_write_s, adr_src_s, mem_write_s, ir_write_s, alu_src_a_s;
  logic       reg_write_s, illegal_s;
  logic [1:0] result_src_s, alu_src_b_s;
  logic [2:0] alu_ctl_s;

  cond_check u_cond_check (
    .Cond    (Cond),
    .Flags   (flags_r),
    .cond_ex (cond_ex_s)
  );

  assign dp_dec_s = dp_decode(Funct[4:1]);
  assign rd_pc_s  = (Rd == 4'd15);

  // The condition is frozen at the end of DECODE so a flag update in EXEC
  // cannot change the outcome of the same instruction's writeback.
  assign flag_load_s = ((state_r == S_EXECR) || (state_r == S_EXECI)) &&
                       Funct[0] && cond_ex_r;

  // State, flag and latched-condition registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_FETCH;
      flags_r   <= FLAG_RESET;
      cond_ex_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (state_r == S_DECODE) begin
        cond_ex_r <= cond_ex_s;
      end
      if (flag_load_s) begin
        flags_r <= dp_dec_s.logic_op ? {ALUFlags[3:2], flags_r[1:0]} : ALUFlags;
      end
    end
  end

  // Next-state selection.
  always_comb begin
    state_next_s = S_FETCH;
    case (state_r)
      S_FETCH:  state_next_s = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:  state_next_s = S_MEMADR;
          OP_DP:   state_next_s = Funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_next_s = S_BRANCH;
          default: state_next_s = UNDEF_TRAP ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: state_next_s = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next_s = S_MEMWB;
      S_EXECR:  state_next_s = S_ALUWB;
      S_EXECI:  state_next_s = S_ALUWB;
      S_HALT:   state_next_s = S_HALT;
      default:  state_next_s = S_FETCH;
    endcase
  end

  // Per-state datapath controls before the reset mask.
  always_comb begin
    pc_write_s   = 1'b0;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    result_src_s = RES_ALUOUT;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = SRCB_REG;
    alu_ctl_s    = ALU_ADD;
    reg_write_s  = 1'b0;
    illegal_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        ir_write_s   = 1'b1;
        pc_write_s   = 1'b1;
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = SRCB_FOUR;
        result_src_s = RES_ALURESULT;
      end
      S_DECODE: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = SRCB_FOUR;
        result_src_s = RES_ALURESULT;
        illegal_s    = (Op == OP_UND);
      end
      S_MEMADR: begin
        alu_src_b_s = SRCB_IMM;
        alu_ctl_s   = Funct[3] ? ALU_ADD : ALU_SUB;
      end
      S_MEMRD: begin
        adr_src_s = 1'b1;
      end
      S_MEMWB: begin
        result_src_s = RES_RDATA;
        reg_write_s  = cond_ex_r & ~rd_pc_s;
        pc_write_s   = cond_ex_r & rd_pc_s;
      end
      S_MEMWR: begin
        adr_src_s   = 1'b1;
        mem_write_s = cond_ex_r;
      end
      S_EXECR: begin
        alu_ctl_s = dp_dec_s.alu_ctl;
      end
      S_EXECI: begin
        alu_src_b_s = SRCB_IMM;
        alu_ctl_s   = dp_dec_s.alu_ctl;
      end
      S_ALUWB: begin
        reg_write_s = cond_ex_r & ~dp_dec_s.no_write & ~rd_pc_s;
        pc_write_s  = cond_ex_r & ~dp_dec_s.no_write & rd_pc_s;
      end
      S_BRANCH: begin
        alu_src_b_s  = SRCB_IMM;
        result_src_s = RES_ALURESULT;
        pc_write_s   = cond_ex_r;
      end
      default: begin
        pc_write_s = 1'b0;
      end
    endcase
  end

  // Reset forces every enable and select low in the same cycle, so an
  // instruction interrupted by reset produces no write.
  assign PCWrite    = reset ? 1'b0 : pc_write_s;
  assign AdrSrc     = reset ? 1'b0 : adr_src_s;
  assign MemWrite   = reset ? 1'b0 : mem_write_s;
  assign IRWrite    = reset ? 1'b0 : ir_write_s;
  assign ResultSrc  = reset ? 2'b00 : result_src_s;
  assign ALUSrcA    = reset ? 1'b0 : alu_src_a_s;
  assign ALUSrcB    = reset ? 2'b00 : alu_src_b_s;
  assign ALUControl = reset ? 3'b000 : alu_ctl_s;
  assign ImmSrc     = reset ? 2'b00 : Op;
  assign RegSrc     = reset ? 2'b00 : {(Op == OP_MEM), (Op == OP_BR)};
  assign RegWrite   = reset ? 1'b0 : reg_write_s;
  assign illegal    = reset ? 1'b0 : illegal_s;
  assign Flags      = flags_r;
  assign state      = state_r;

endmodule

// File: tb/tb_mc_fsm_controller.sv
// Directed bench for the multi-cycle ARM control unit: walks each
// instruction class cycle by cycle against hand-computed control values.
module tb_mc_fsm_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd, Cond, ALUFlags;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0] ALUControl;
  logic [3:0] Flags, state;

  int vectors = 0;
  int miscompares = 0;

  mc_fsm_controller #(.FLAG_RESET(4'b0000), .UNDEF_TRAP(1'b0)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegWrite(RegWrite),
    .Flags(Flags), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [5:0] fn,
                           input logic [3:0] rd, input logic [3:0] cnd,
                           input logic [3:0] alu_flags);
    Op = op; Funct = fn; Rd = rd; Cond = cnd; ALUFlags = alu_flags;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    set_instr(2'b00, 6'b101000, 4'd1, 4'b1110, 4'b0000);
    tick; tick;
    vectors++; if (IRWrite !== 1'b0) begin miscompares++; $display("FAIL reset_irwrite got=%b exp=0", IRWrite); end
    vectors++; if (PCWrite !== 1'b0) begin miscompares++; $display("FAIL reset_pcwrite got=%b exp=0", PCWrite); end
    reset = 1'b0;
    #1;
    vectors++; if (state !== 4'd0) begin miscompares++; $display("FAIL reset_state got=%0d exp=0", state); end
    vectors++; if (Flags !== 4'b0000) begin miscompares++; $display("FAIL reset_flags got=%b exp=0000", Flags); end
    vectors++; if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin miscompares++; $display("FAIL fetch_enables got IR=%b PC=%b exp 1 1", IRWrite, PCWrite); end
  endtask

  // ADD R1,R2,#5 unconditional
  task automatic test_add_imm;
    set_instr(2'b00, 6'b101000, 4'd1, 4'b1110, 4'b0000);
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL add_fetch_regwrite got=%b exp=0", RegWrite); end
    tick;
    vectors++; if (state !== 4'd1 || RegWrite !== 1'b0 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10) begin
      miscompares++; $display("FAIL add_decode got st=%0d rw=%b a=%b b=%b exp 1 0 1 10", state, RegWrite, ALUSrcA, ALUSrcB); end
    tick;
    vectors++; if (state !== 4'd7 || ALUSrcB !== 2'b01 || ALUControl !== 3'b000 || RegWrite !== 1'b0) begin
      miscompares++; $display("FAIL add_execi got st=%0d b=%b ctl=%b rw=%b exp 7 01 000 0", state, ALUSrcB, ALUControl, RegWrite); end
    tick;
    vectors++; if (state !== 4'd8 || RegWrite !== 1'b1 || PCWrite !== 1'b0 || ResultSrc !== 2'b00) begin
      miscompares++; $display("FAIL add_aluwb got st=%0d rw=%b pc=%b rs=%b exp 8 1 0 00", state, RegWrite, PCWrite, ResultSrc); end
    tick;
    vectors++; if (state !== 4'd0) begin miscompares++; $display("FAIL add_return got=%0d exp=0", state); end
  endtask

  // SUBS R1,R1,#imm giving zero, then BEQ taken
  task automatic test_subs_beq;
    set_instr(2'b00, 6'b100101, 4'd1, 4'b1110, 4'b0100);
    tick; tick;
    vectors++; if (ALUControl !== 3'b001) begin miscompares++; $display("FAIL subs_aluctl got=%b exp=001", ALUControl); end
    tick;
    vectors++; if (Flags !== 4'b0100) begin miscompares++; $display("FAIL subs_flags got=%b exp=0100", Flags); end
    tick;
    set_instr(2'b10, 6'b100000, 4'd0, 4'b0000, 4'b0000);
    tick; tick;
    vectors++; if (state !== 4'd9 || PCWrite !== 1'b1 || ALUSrcB !== 2'b01 || ResultSrc !== 2'b10) begin
      miscompares++; $display("FAIL beq_branch got st=%0d pc=%b b=%b rs=%b exp 9 1 01 10", state, PCWrite, ALUSrcB, ResultSrc); end
    tick;
    vectors++; if (state !== 4'd0) begin miscompares++; $display("FAIL beq_length got=%0d exp=0", state); end
  endtask

  // BNE with Z=1, ADDS clearing Z, then STREQ with Z=0
  task automatic test_cond_fail;
    set_instr(2'b10, 6'b100000, 4'd0, 4'b0001, 4'b0000);
    tick; tick;
    vectors++; if (state !== 4'd9 || PCWrite !== 1'b0) begin
      miscompares++; $display("FAIL bne_notaken got st=%0d pc=%b exp 9 0", state, PCWrite); end
    tick;
    set_instr(2'b00, 6'b101001, 4'd2, 4'b1110, 4'b0000);
    tick; tick; tick; tick;
    vectors++; if (Flags !== 4'b0000) begin miscompares++; $display("FAIL adds_flags got=%b exp=0000", Flags); end
    set_instr(2'b01, 6'b011000, 4'd3, 4'b0000, 4'b0000);
    tick; tick;
    vectors++; if (state !== 4'd2 || ALUSrcA !== 1'b0 || ALUSrcB !== 2'b01 || ALUControl !== 3'b000) begin
      miscompares++; $display("FAIL str_memadr got st=%0d a=%b b=%b ctl=%b exp 2 0 01 000", state, ALUSrcA, ALUSrcB, ALUControl); end
    tick;
    vectors++; if (state !== 4'd5 || MemWrite !== 1'b0 || AdrSrc !== 1'b1) begin
      miscompares++; $display("FAIL streq_memwr got st=%0d mw=%b adr=%b exp 5 0 1", state, MemWrite, AdrSrc); end
    tick;
    vectors++; if (state !== 4'd0) begin miscompares++; $display("FAIL str_length got=%0d exp=0", state); end
  endtask

  // LDR R15 with down offset
  task automatic test_ldr_pc;
    set_instr(2'b01, 6'b010001, 4'd15, 4'b1110, 4'b0000);
    tick;
    vectors++; if (ImmSrc !== 2'b01 || RegSrc !== 2'b10) begin
      miscompares++; $display("FAIL ldr_decode got imm=%b reg=%b exp 01 10", ImmSrc, RegSrc); end
    tick;
    vectors++; if (state !== 4'd2 || ALUControl !== 3'b001) begin
      miscompares++; $display("FAIL ldr_memadr_sub got st=%0d ctl=%b exp 2 001", state, ALUControl); end
    tick;
    vectors++; if (state !== 4'd3 || AdrSrc !== 1'b1 || ResultSrc !== 2'b00) begin
      miscompares++; $display("FAIL ldr_memrd got st=%0d adr=%b rs=%b exp 3 1 00", state, AdrSrc, ResultSrc); end
    tick;
    vectors++; if (state !== 4'd4 || PCWrite !== 1'b1 || RegWrite !== 1'b0 || ResultSrc !== 2'b01) begin
      miscompares++; $display("FAIL ldr_memwb got st=%0d pc=%b rw=%b rs=%b exp 4 1 0 01", state, PCWrite, RegWrite, ResultSrc); end
    tick;
    vectors++; if (state !== 4'd0) begin miscompares++; $display("FAIL ldr_length got=%0d exp=0", state); end
  endtask

  // ADDS sets CV, ANDS keeps CV, CMP writes flags but no register
  task automatic test_logic_flags;
    set_instr(2'b00, 6'b101001, 4'd1, 4'b1110, 4'b0011);
    tick; tick; tick; tick;
    set_instr(2'b00, 6'b000001, 4'd1, 4'b1110, 4'b1000);
    tick; tick;
    vectors++; if (state !== 4'd6 || ALUControl !== 3'b010 || ALUSrcB !== 2'b00) begin
      miscompares++; $display("FAIL ands_execr got st=%0d ctl=%b b=%b exp 6 010 00", state, ALUControl, ALUSrcB); end
    tick;
    vectors++; if (Flags !== 4'b1011) begin miscompares++; $display("FAIL ands_keep_cv got=%b exp=1011", Flags); end
    tick;
    set_instr(2'b00, 6'b010101, 4'd1, 4'b1110, 4'b0110);
    tick; tick; tick;
    vectors++; if (RegWrite !== 1'b0 || PCWrite !== 1'b0 || Flags !== 4'b0110) begin
      miscompares++; $display("FAIL cmp_aluwb got rw=%b pc=%b fl=%b exp 0 0 0110", RegWrite, PCWrite, Flags); end
    tick;
  endtask

  // ADDSEQ with Z=1 clearing Z: writeback still uses the old condition
  task automatic test_flag_visibility;
    set_instr(2'b00, 6'b101001, 4'd2, 4'b0000, 4'b1001);
    tick; tick; tick;
    vectors++; if (Flags !== 4'b1001 || RegWrite !== 1'b1) begin
      miscompares++; $display("FAIL addseq_aluwb got fl=%b rw=%b exp 1001 1", Flags, RegWrite); end
    tick;
  endtask

  // Reset during MEMWR of an unconditional STR
  task automatic test_reset_mid;
    set_instr(2'b01, 6'b011000, 4'd3, 4'b1110, 4'b0000);
    tick; tick; tick;
    vectors++; if (state !== 4'd5 || MemWrite !== 1'b1) begin
      miscompares++; $display("FAIL str_memwrite got st=%0d mw=%b exp 5 1", state, MemWrite); end
    reset = 1'b1;
    #1;
    vectors++; if (MemWrite !== 1'b0 || AdrSrc !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid_gate got mw=%b adr=%b exp 0 0", MemWrite, AdrSrc); end
    tick;
    reset = 1'b0;
    #1;
    vectors++; if (state !== 4'd0 || Flags !== 4'b0000) begin
      miscompares++; $display("FAIL reset_mid_state got st=%0d fl=%b exp 0 0000", state, Flags); end
  endtask

  // Undefined Op with UNDEF_TRAP=0
  task automatic test_undef;
    set_instr(2'b11, 6'b000000, 4'd0, 4'b1110, 4'b0000);
    vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL undef_fetch_illegal got=%b exp=0", illegal); end
    tick;
    vectors++; if (state !== 4'd1 || illegal !== 1'b1) begin
      miscompares++; $display("FAIL undef_decode got st=%0d ill=%b exp 1 1", state, illegal); end
    tick;
    vectors++; if (state !== 4'd0 || illegal !== 1'b0) begin
      miscompares++; $display("FAIL undef_return got st=%0d ill=%b exp 0 0", state, illegal); end
  endtask

  initial begin
    test_reset;
    test_add_imm;
    test_subs_beq;
    test_cond_fail;
    test_ldr_pc;
    test_logic_flags;
    test_flag_visibility;
    test_reset_mid;
    test_undef;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
